// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
//
// Write-back scheduler for the 32x32 register file. The file has a single
// synchronous write port. Two requesters share it: the ALU result path (port A)
// and the load result path (port B).
//
// After every reset the block runs a clear sequence. It writes zero to
// x1..x(2^AW-1), one register per cycle. Only after that does it accept
// requests.
//
// Optional feature macro: WB_BYPASS_EN. When it is defined, combinational
// read-port forwarding is added. It covers the cycle in which a registered
// write is on we/WriteAddr/WriteData but the file has not yet committed it.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   a_valid/a_addr/a_data, a_ready   ALU write-back request / accept
//   b_valid/b_addr/b_data, b_ready   load write-back request / accept
//   we, WriteAddr, WriteData         registered register-file write port
//   init_done           clear sequence finished, requests may be granted
//   ReadAddr1/2, rf_data1/2 -> fwd_data1/2   (WB_BYPASS_EN only) forwarding
//   dbg_state           0 = CLEAR, 1 = RUN
//
// Handshake: a transfer happens on a rising edge where x_valid && x_ready.
// A requester keeps valid/addr/data stable until it is accepted. ready is a
// combinational function of state, both valids and the round-robin pointer.
// It never depends on the other port's ready. At most one ready is high per
// cycle.
// -----------------------------------------------------------------------------
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            we,
  output logic [AW-1:0]   WriteAddr,
  output logic [XLEN-1:0] WriteData,
  output logic            init_done,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0]   ReadAddr1,
  input  logic [AW-1:0]   ReadAddr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
`endif
  output logic            dbg_state
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic          LAST_A   = 1'b0;
  localparam logic          LAST_B   = 1'b1;
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic          last;
  logic          a_grant;
  logic          b_grant;

  // On a tie, the port that was not granted last wins.
  always_comb begin
    a_grant = (state == RUN) && a_valid && (!b_valid || (last == LAST_B));
    b_grant = (state == RUN) && b_valid && (!a_valid || (last == LAST_A));
  end

  assign a_ready   = a_grant;
  assign b_ready   = b_grant;
  assign dbg_state = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      clr_idx   <= AW'(1);
      last      <= LAST_B;
      we        <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // The top register was issued on the previous edge. Spend this edge
          // leaving CLEAR, so ready stays low until init_done is visible.
          if (we && (WriteAddr == ADDR_MAX)) begin
            state     <= RUN;
            init_done <= 1'b1;
            we        <= 1'b0;
          end else begin
            we        <= 1'b1;
            WriteAddr <= clr_idx;
            WriteData <= '0;
            // Saturate at the top so the index can never wrap back to x0.
            if (clr_idx != ADDR_MAX) clr_idx <= clr_idx + 1'b1;
          end
        end
        RUN: begin
          // Writes to x0 are accepted but dropped. They do not count as a
          // turn, so the round-robin pointer is left alone.
          if (a_grant) begin
            if (a_addr != '0) begin
              we        <= 1'b1;
              WriteAddr <= a_addr;
              WriteData <= a_data;
              last      <= LAST_A;
            end else begin
              we <= 1'b0;
            end
          end else if (b_grant) begin
            if (b_addr != '0) begin
              we        <= 1'b1;
              WriteAddr <= b_addr;
              WriteData <= b_data;
              last      <= LAST_B;
            end else begin
              we <= 1'b0;
            end
          end else begin
            we <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // x0 always reads as zero. Otherwise a pending write to the same register
  // overrides the stale file data.
  always_comb begin
    fwd_data1 = rf_data1;
    if (ReadAddr1 == '0)
      fwd_data1 = '0;
    else if (we && (WriteAddr == ReadAddr1))
      fwd_data1 = WriteData;
  end

  always_comb begin
    fwd_data2 = rf_data2;
    if (ReadAddr2 == '0)
      fwd_data2 = '0;
    else if (we && (WriteAddr == ReadAddr2))
      fwd_data2 = WriteData;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_sched
//
// Self-checking bench for regfile_wb_sched.
//
// A reference arbiter model predicts ready and the registered write for every
// edge. Predicted writes go into exp_q when inputs are presented. They are
// popped and compared after the edge. Requesters are fed from per-port item
// queues. Items are held valid until granted.
//
// Compile with +define+WB_BYPASS_EN to also exercise forwarding.
// -----------------------------------------------------------------------------
module tb_regfile_wb_sched;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int EW   = 1 + AW + XLEN;
  localparam int IW   = AW + XLEN;

  logic            clk;
  logic            rst;
  logic            a_valid, b_valid;
  logic [AW-1:0]   a_addr, b_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic            a_ready, b_ready;
  logic            we;
  logic [AW-1:0]   WriteAddr;
  logic [XLEN-1:0] WriteData;
  logic            init_done;
  logic            dbg_state;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]   ReadAddr1, ReadAddr2;
  logic [XLEN-1:0] rf_data1, rf_data2;
  logic [XLEN-1:0] fwd_data1, fwd_data2;
`endif

  regfile_wb_sched #(.XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .we        (we),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .init_done (init_done),
`ifdef WB_BYPASS_EN
    .ReadAddr1 (ReadAddr1),
    .ReadAddr2 (ReadAddr2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] a_q[$];
  logic [IW-1:0] b_q[$];
  int  n_checks;
  int  n_pass;
  int  m_cyc;     // edges since reset release
  bit  m_last;    // model pointer: 1 = B granted last
  bit  rnd_gap;   // random idle gaps before presenting items

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_inputs();
    logic [IW-1:0] it;
    if (!a_valid && a_q.size() > 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
      it = a_q.pop_front();
      a_addr = it[IW-1:XLEN];
      a_data = it[XLEN-1:0];
      a_valid = 1'b1;
    end
    if (!b_valid && b_q.size() > 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
      it = b_q.pop_front();
      b_addr = it[IW-1:XLEN];
      b_data = it[XLEN-1:0];
      b_valid = 1'b1;
    end
  endtask

  // Asserts reset asynchronously at the current time and checks that the
  // outputs clear at once. Releases reset just after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd3; b_addr = 5'd4;
    #1;
    check("rst_we", we, 0);
    check("rst_waddr", WriteAddr, 0);
    check("rst_wdata", WriteData, 0);
    check("rst_init_done", init_done, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_we", we, 0);
    check("rst_hold_waddr", WriteAddr, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    a_q.delete(); b_q.delete(); exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_cyc = 0;
    m_last = 1'b1;
  endtask

  // One clock: predict at the falling edge, compare after the rising edge.
  task automatic step();
    logic          ea, eb;
    int            k;
    logic [EW-1:0] e;
    @(negedge clk);
    k = m_cyc + 1;
    ea = 1'b0; eb = 1'b0;
    if (m_cyc >= 32) begin
      ea = a_valid && (!b_valid || m_last);
      eb = b_valid && (!a_valid || !m_last);
    end
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    check("init_done", init_done, (m_cyc >= 32));
    if (k <= 31)                    e = {1'b1, AW'(k), {XLEN{1'b0}}};
    else if (ea && a_addr != '0)    e = {1'b1, a_addr, a_data};
    else if (eb && b_addr != '0)    e = {1'b1, b_addr, b_data};
    else                            e = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("we", we, e[EW-1]);
    if (e[EW-1]) begin
      check("waddr", WriteAddr, e[EW-2:XLEN]);
      check("wdata", WriteData, e[XLEN-1:0]);
    end
    if (ea && a_addr != '0) m_last = 1'b0;
    if (eb && b_addr != '0) m_last = 1'b1;
    m_cyc++;
    if (ea) a_valid = 1'b0;
    if (eb) b_valid = 1'b0;
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (a_valid || b_valid || a_q.size() != 0 || b_q.size() != 0); i++)
      step();
    check("drained", a_q.size() + b_q.size() + int'(a_valid) + int'(b_valid), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; rnd_gap = 1'b0;
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
`ifdef WB_BYPASS_EN
    ReadAddr1 = '0; ReadAddr2 = '0; rf_data1 = '0; rf_data2 = '0;
`endif
    #12;

    // Clear sequence with both requesters idle.
    do_reset();
    repeat (33) step();

    // Tie: A first, then B.
    a_q.push_back({5'd5, 32'h11});
    b_q.push_back({5'd6, 32'h22});
    drive_inputs();
    drain(10);

    // Continuous tie for six grants: A,B,A,B,A,B.
    for (int i = 0; i < 3; i++) begin
      a_q.push_back({AW'(10 + i), 32'hA0 + 32'(i)});
      b_q.push_back({AW'(20 + i), 32'hB0 + 32'(i)});
    end
    drive_inputs();
    repeat (6) step();
    check("burst_done", a_q.size() + b_q.size() + int'(a_valid) + int'(b_valid), 0);

    // x0 write is accepted without a write, and the pointer stays at B.
    a_q.push_back({5'd0, 32'hDEAD});
    drive_inputs();
    step();
    a_q.push_back({5'd9, 32'h99});
    b_q.push_back({5'd10, 32'hAA});
    drive_inputs();
    drain(10);

    // Random traffic with idle gaps and occasional x0 targets.
    rnd_gap = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a_q.push_back({AW'($urandom_range(0, 31)), 32'($urandom)});
      b_q.push_back({AW'($urandom_range(0, 31)), 32'($urandom)});
    end
    drive_inputs();
    drain(300);
    rnd_gap = 1'b0;

    // Reset mid-clear (clr_idx = 12) with requests pending; restart from x1.
    do_reset();
    repeat (11) step();
    check("mid_clear_waddr", WriteAddr, 11);
    do_reset();
    a_q.push_back({5'd17, 32'h1234_5678});
    b_q.push_back({5'd18, 32'h8765_4321});
    drive_inputs();
    repeat (32) step();
    drain(10);

`ifdef WB_BYPASS_EN
    a_q.push_back({5'd7, 32'h55});
    drive_inputs();
    step();
    ReadAddr1 = 5'd7; rf_data1 = 32'h0;
    ReadAddr2 = 5'd0; rf_data2 = 32'h99;
    #1;
    check("fwd1_bypass", fwd_data1, 32'h55);
    check("fwd2_x0", fwd_data2, 32'h0);
    ReadAddr2 = 5'd8; rf_data2 = 32'h77;
    #1;
    check("fwd2_nomatch", fwd_data2, 32'h77);
    step();
    ReadAddr1 = 5'd7; rf_data1 = 32'h55;
    #1;
    check("fwd1_file", fwd_data1, 32'h55);
    rf_data1 = 32'h66;
    #1;
    check("fwd1_no_stale", fwd_data1, 32'h66);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the 32×32 register file. It shares the register file's single synchronous write port between two write-back requesters: the ALU result path (port A) and the load/memory result path (port B). After every reset it first runs a clear sequence that writes zero to x1..x31, one register per cycle, before accepting requests. It sits between the execute/memory stages and the register file, and drives the file's `we`/`WriteAddr`/`WriteData` inputs.

## Interface
- `XLEN`, default 32: data width of write-back values.
- `AW`, default 5: register address width (32 registers).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `a_valid`  in  1  ALU requester has a write-back.
- `a_addr`  in  AW  ALU destination register.
- `a_data`  in  XLEN  ALU result.
- `a_ready`  out  1  ALU request accepted this cycle.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as the `a_*` ports, for the load requester.
- `we`  out  1  register-file write enable (registered).
- `WriteAddr`  out  AW  register-file write address (registered).
- `WriteData`  out  XLEN  register-file write data (registered).
- `init_done`  out  1  clear sequence complete; requests may be granted.
- The following ports exist only with `WB_BYPASS_EN`:
  - `ReadAddr1`, `ReadAddr2`  in  AW  read addresses presented to the file.
  - `rf_data1`, `rf_data2`  in  XLEN  raw file read data.
  - `fwd_data1`, `fwd_data2`  out  XLEN  forwarded read data.

## Operation
- States: CLEAR, RUN.
- **CLEAR** (entered on reset):
  - `clr_idx` starts at 1.
  - Each cycle: `we`=1, `WriteAddr`=`clr_idx`, `WriteData`=0, then `clr_idx` increments.
  - After writing 31, go to RUN and set `init_done`=1.
  - `a_ready` = `b_ready` = 0 throughout.
- **RUN**: a handshake occurs when `x_valid` && `x_ready` in the same cycle.
  - Only one requester is granted per cycle.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: round-robin. Pointer `last` holds the last granted port; grant the other one, then update `last`.
  - A grant with `addr`≠0 registers `we`=1, `WriteAddr`=addr, `WriteData`=data for the next cycle.
  - A grant with `addr`=0 is accepted (ready=1) but produces `we`=0. It does not update `last`.
  - No grant: `we`=0. `WriteAddr`/`WriteData` hold their previous values.
  - `ready` is combinational from state, valids and `last`. Ready does not depend on ready.
  - A requester must hold valid/addr/data stable until accepted.
- Width rules:
  - `clr_idx` is AW bits and must never wrap to 0.
  - Data passes through unmodified; there is no arithmetic on data.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `we`=0, `WriteAddr`=0, `WriteData`=0, `init_done`=0.
  - state=CLEAR, `clr_idx`=1, `last`=B, so A wins the first tie.
- Release of reset:
  - First rising edge with `rst`=1 → `we`=1, `WriteAddr`=1.
  - The 31st such edge → `WriteAddr`=31.
  - The 32nd edge → `we`=0 (unless a grant occurs in that cycle; ready is still 0 then, so no grant) and `init_done`=1.
- Grant latency: a handshake at edge N puts the write on `we`/`WriteAddr`/`WriteData` after edge N. The register file commits it at edge N+1.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate A, B, A, B, ...
- Reset asserted mid-CLEAR or mid-RUN:
  - Immediate return to reset values.
  - Any in-flight registered write is dropped (`we` goes to 0 asynchronously).
  - The clear sequence restarts from x1.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwd_dataK` = `WriteData` when `we`=1 && `WriteAddr`==`ReadAddrK` && `ReadAddrK`≠0.
  - Otherwise `fwd_dataK` = `rf_dataK`.
  - `fwd_dataK` is forced to 0 when `ReadAddrK`=0.
  - Purely combinational; this covers the one cycle before the file commits the write.
- `WB_BYPASS_EN` undefined:
  - The bypass ports and logic are absent.
  - Consumers read the file directly and see a write one cycle after `we`.

## Test plan
- Reset, then release with both valids low → `we`=1 for exactly 31 cycles with `WriteAddr`=1..31 and `WriteData`=0. `init_done` rises on the 32nd cycle. `a_ready`/`b_ready` stay 0 until then.
- In RUN, A(addr 5, 0x11) and B(addr 6, 0x22) valid together and held → A granted first. Next cycle `we`=1/5/0x11. Then B is granted and `we`=1/6/0x22 follows.
- Both requesters valid continuously for 6 cycles with distinct addresses → grant sequence A, B, A, B, A, B; no cycle without a grant.
- A valid with addr 0 and data 0xDEAD → `a_ready`=1 and next cycle `we`=0. A following tie between A and B still goes to A (`last` unchanged).
- Assert `rst` low when `clr_idx`=12, release 3 cycles later → outputs are 0 during reset; the clear sequence restarts at `WriteAddr`=1 and runs the full 31 writes.
- With `WB_BYPASS_EN`: A writes 0x55 to x7, and `ReadAddr1`=7 with `rf_data1`=0 in the `we` cycle → `fwd_data1`=0x55. In the next cycle, with `we`=0 and `rf_data1`=0x55 → `fwd_data1`=0x55. With `ReadAddr2`=0 → `fwd_data2`=0.
